// File: rtl/div_pkg.sv
// Shared widths and state encoding for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DW = 18;
  localparam int unsigned VW = 16;
  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_div18_if.sv
// Operand and result valid/ready handshake bundle of the divider.
interface seq_div18_if;
  import div_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div0;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div0
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div0
  );

endinterface

// File: rtl/div_trial_sub.sv
// Trial subtract P' - D as P' + ~D + 1 over VW+1 bits; borrow=0 means P' >= D.
module div_trial_sub import div_pkg::*; (
  input  logic [VW:0]   p,
  input  logic [VW-1:0] d,
  output logic [VW-1:0] diff,
  output logic          borrow
);

  logic [VW:0]   d_ext;
  logic [VW:0]   sum;
  logic [VW+1:0] carry;
  logic          unused_msb;

  assign d_ext    = {1'b0, d};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < int'(VW) + 1; i++) begin : g_fa
    fulladd u_fa (
      .a  (p[i]),
      .b  (~d_ext[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // A kept difference is always below D, so its top bit is zero.
  assign diff       = sum[VW-1:0];
  assign unused_msb = sum[VW];
  assign borrow     = ~carry[VW+1];

endmodule

// File: rtl/fulladd.sv
// One-bit full adder cell.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/seq_div18.sv
// Radix-2 restoring divider: 18-bit dividend / 16-bit divisor, one quotient bit per cycle.
module seq_div18 import div_pkg::*; (
  input logic        clk,
  input logic        rst,
  seq_div18_if.slave bus
);

  state_e        state_q, state_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] p_q, p_d;
  logic [VW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          div0_q, div0_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [VW:0]   p_shift;
  logic [VW-1:0] diff;
  logic          borrow;
  logic [VW-1:0] p_next;
  logic [DW-1:0] q_shift;

  assign p_shift = {p_q, q_q[DW-1]};
  assign q_shift = {q_q[DW-2:0], ~borrow};
  assign p_next  = borrow ? p_shift[VW-1:0] : diff;

  div_trial_sub u_sub (
    .p      (p_shift),
    .d      (d_q),
    .diff   (diff),
    .borrow (borrow)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DONE releases only once the result has actually been shown
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = (bus.divisor == '0) ? ST_DONE : ST_BUSY;
      ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: if (out_valid_q && bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    q_d         = q_q;
    p_d         = p_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    div0_d      = div0_q;
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          q_d   = bus.dividend;
          d_d   = bus.divisor;
          p_d   = '0;
          cnt_d = CW'(DW - 1);
          if (bus.divisor == '0) begin
            quot_d = '1;
            rem_d  = bus.dividend[VW-1:0];
            div0_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        q_d   = q_shift;
        p_d   = p_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quot_d      = q_shift;
          rem_d       = p_next;
          div0_d      = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: out_valid_d = !(out_valid_q && bus.out_ready);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q         <= '0;
      p_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      div0_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      p_q         <= p_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      div0_q      <= div0_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div0      = div0_q;

endmodule

// File: tb/tb_seq_div18.sv
// Randomized self-checking bench for seq_div18 against a plain / and % reference.
module tb_seq_div18;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  seq_div18_if bus ();

  seq_div18 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_quot(input logic [DW-1:0] a, input logic [VW-1:0] b);
    if (b == '0) return '1;
    return a / DW'(b);
  endfunction

  function automatic logic [VW-1:0] ref_rem(input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [DW-1:0] r;
    if (b == '0) return a[VW-1:0];
    r = a % DW'(b);
    return r[VW-1:0];
  endfunction

  // Present one op, wait for the accept edge, then count edges until out_valid.
  task automatic issue_and_wait(input logic [DW-1:0] a, input logic [VW-1:0] b, output int lat);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    bus.in_valid  = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = DW'($urandom);
    bus.divisor  = VW'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                              input int lat);
    check({tag, "_lat"},  32'(lat), (b == '0) ? 32'd1 : 32'(DW));
    check({tag, "_quot"}, 32'(bus.quotient), 32'(ref_quot(a, b)));
    check({tag, "_rem"},  32'(bus.remainder), 32'(ref_rem(a, b)));
    check({tag, "_div0"}, 32'(bus.div0), 32'(b == '0));
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_idle_ov"},  32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b);
    int lat;
    issue_and_wait(a, b, lat);
    check_result(tag, a, b, lat);
    release_result(tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    logic seen_idle;
    logic [DW-1:0] a;
    logic [VW-1:0] b;

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quot",      32'(bus.quotient), 32'd0);
    check("rst_rem",       32'(bus.remainder), 32'd0);
    check("rst_div0",      32'(bus.div0), 32'd0);
    rst = 1'b0;

    run_op("d100000_7", 18'd100000, 16'd7);
    run_op("d1234_0",   18'd1234, 16'd0);
    run_op("dmax_1",    18'h3FFFF, 16'd1);
    run_op("dmax_max",  18'h3FFFF, 16'hFFFF);
    run_op("d5_max",    18'd5, 16'hFFFF);
    run_op("dvmax_max", 18'd65535, 16'hFFFF);
    run_op("d0_9",      18'd0, 16'd9);

    // Back-pressure: result must hold while in_valid and operands wiggle
    issue_and_wait(18'd100000, 16'd7, lat);
    check_result("hold", 18'd100000, 16'd7, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.dividend = DW'($urandom);
      bus.divisor  = VW'($urandom);
      check("hold_quot", 32'(bus.quotient), 32'd14285);
      check("hold_rem",  32'(bus.remainder), 32'd5);
      check("hold_ov",   32'(bus.out_valid), 32'd1);
      check("hold_rdy",  32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    release_result("hold");

    // Reset in the middle of an iteration sequence
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 18'd50000;
    bus.divisor  = 16'd7;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ov",   32'(bus.out_valid), 32'd0);
    check("midrst_rdy",  32'(bus.in_ready), 32'd1);
    check("midrst_quot", 32'(bus.quotient), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("d1000_3", 18'd1000, 16'd3);

    // Throughput with out_ready and in_valid held high
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dividend  = 18'd77777;
    bus.divisor   = 16'd13;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    seen_idle = 1'b0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (bus.in_ready) seen_idle = 1'b1;
      else if (seen_idle) break;
    end
    check("tput_accept_gap", 32'(k), 32'(DW + 2));
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("tput_drain", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;

    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = VW'($urandom_range(1, 15));
        2:       b = '1;
        default: b = VW'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       a = '0;
        1:       a = '1;
        default: a = DW'($urandom);
      endcase
      run_op("rand", a, b);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
